// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control sequencer: state codes, opcodes,
// select codes and the instruction-class bit positions.
package mc_pkg;

    localparam logic [2:0] S_IF   = 3'd0;
    localparam logic [2:0] S_ID   = 3'd1;
    localparam logic [2:0] S_EX   = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_WB   = 3'd4;
    localparam logic [2:0] S_HALT = 3'd5;
    localparam logic [2:0] S_TRAP = 3'd6;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LD    = 7'b0000011;
    localparam logic [6:0] OP_ST    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    localparam logic [1:0] PCS_SEQ  = 2'd0;
    localparam logic [1:0] PCS_JAL  = 2'd2;
    localparam logic [1:0] PCS_JALR = 2'd3;

    localparam logic [1:0] WBS_ALU  = 2'd0;
    localparam logic [1:0] WBS_MEM  = 2'd1;
    localparam logic [1:0] WBS_PC4  = 2'd2;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_CMP  = 2'd1;
    localparam logic [1:0] ALU_FN   = 2'd2;
    localparam logic [1:0] ALU_LUI  = 2'd3;

    // Bit positions inside the one-hot class vector.
    typedef enum int unsigned {
        CL_ALU_R = 0, CL_ALU_I, CL_LUI, CL_AUIPC, CL_LD,
        CL_ST, CL_BR, CL_JAL, CL_JALR, CL_ILL, CL_NUM
    } cls_e;

    typedef logic [CL_NUM-1:0] cls_t;

endpackage

// File: rtl/mc_inst_class.sv
// Combinational opcode classifier: OPCODE -> one-hot instruction class.
// Anything not in the supported set lands in the ILL bit.
module mc_inst_class
    import mc_pkg::*;
(
    input  logic [6:0] opcode_i,
    output cls_t       cls_o
);

    always_comb begin
        cls_o = '0;
        case (opcode_i)
            OP_R:     cls_o[CL_ALU_R] = 1'b1;
            OP_I:     cls_o[CL_ALU_I] = 1'b1;
            OP_LUI:   cls_o[CL_LUI]   = 1'b1;
            OP_AUIPC: cls_o[CL_AUIPC] = 1'b1;
            OP_LD:    cls_o[CL_LD]    = 1'b1;
            OP_ST:    cls_o[CL_ST]    = 1'b1;
            OP_BR:    cls_o[CL_BR]    = 1'b1;
            OP_JAL:   cls_o[CL_JAL]   = 1'b1;
            OP_JALR:  cls_o[CL_JALR]  = 1'b1;
            default:  cls_o[CL_ILL]   = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer driving all datapath strobes and selects,
// with a bounded D-mem wait in MEM and absorbing HALT/TRAP states.
module mc_control_fsm
    import mc_pkg::*;
#(
    parameter int DACK_TIMEOUT = 15,
    parameter int CNT_W        = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] OPCODE,
    input  logic [2:0] FUNCT3,
    input  logic       BR_TAKEN,
    input  logic       HALT_REQ,
    input  logic       D_ACK,
    output logic [2:0] STATE,
    output logic       IR_WE,
    output logic       PC_WE,
    output logic [1:0] PC_SEL,
    output logic       ALU_SRC1,
    output logic       ALU_SRC2,
    output logic [1:0] ALU_OP,
    output logic       D_REQ,
    output logic       D_WE,
    output logic       RF_WE,
    output logic [1:0] WB_SEL,
    output logic       INST_DONE,
    output logic       HALTED,
    output logic       ERR
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DACK_TIMEOUT - 1);

    logic [2:0]       state_q, state_d;
    cls_t             cls_q, cls_d, cls_id;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, err_q;

    mc_inst_class u_cls (
        .opcode_i (OPCODE),
        .cls_o    (cls_id)
    );

    // FUNCT3 only matters for byte-lane selection, which lives outside this block.
    logic unused_ok;
    assign unused_ok = ^{FUNCT3, cls_q[CL_ILL]};

    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IF:  state_d = S_ID;
            S_ID: begin
                cls_d = cls_id;
                if (HALT_REQ)            state_d = S_HALT;
                else if (cls_id[CL_ILL]) state_d = S_TRAP;
                else                     state_d = S_EX;
            end
            S_EX: begin
                if (cls_q[CL_BR])                     state_d = S_IF;
                else if (cls_q[CL_LD] || cls_q[CL_ST]) state_d = S_MEM;
                else                                  state_d = S_WB;
            end
            S_MEM: begin
                // An ACK arriving on the final allowed cycle still completes.
                if (D_ACK) begin
                    cnt_d   = '0;
                    state_d = cls_q[CL_ST] ? S_IF : S_WB;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_TRAP;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_TRAP;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IF;
            cls_q    <= '0;
            cnt_q    <= '0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_q | (state_d == S_HALT);
            err_q    <= err_q | (state_d == S_TRAP);
        end
    end

    logic ex_like;
    assign ex_like = (state_q == S_EX) || (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        STATE     = state_q;
        IR_WE     = 1'b0;
        PC_WE     = 1'b0;
        PC_SEL    = PCS_SEQ;
        ALU_SRC1  = 1'b0;
        ALU_SRC2  = 1'b0;
        ALU_OP    = ALU_ADD;
        D_REQ     = 1'b0;
        D_WE      = 1'b0;
        RF_WE     = 1'b0;
        WB_SEL    = WBS_ALU;
        INST_DONE = 1'b0;
        HALTED    = 1'b0;
        ERR       = 1'b0;
        // Reset suppresses every strobe, including a store completing in MEM.
        if (!RST) begin
            HALTED = halted_q;
            ERR    = err_q;
            if (ex_like) begin
                ALU_SRC1 = cls_q[CL_AUIPC] | cls_q[CL_JAL];
                ALU_SRC2 = cls_q[CL_ALU_I] | cls_q[CL_AUIPC] | cls_q[CL_LD] |
                           cls_q[CL_ST] | cls_q[CL_JAL] | cls_q[CL_JALR];
                if (cls_q[CL_BR])                          ALU_OP = ALU_CMP;
                else if (cls_q[CL_ALU_R] || cls_q[CL_ALU_I]) ALU_OP = ALU_FN;
                else if (cls_q[CL_LUI])                    ALU_OP = ALU_LUI;
                else                                       ALU_OP = ALU_ADD;
            end
            case (state_q)
                S_IF: IR_WE = 1'b1;
                S_EX: begin
                    if (cls_q[CL_BR]) begin
                        PC_WE     = 1'b1;
                        INST_DONE = 1'b1;
                        PC_SEL    = {1'b0, BR_TAKEN};
                    end
                end
                S_MEM: begin
                    D_REQ = 1'b1;
                    D_WE  = cls_q[CL_ST];
                    if (D_ACK && cls_q[CL_ST]) begin
                        PC_WE     = 1'b1;
                        INST_DONE = 1'b1;
                    end
                end
                S_WB: begin
                    RF_WE     = 1'b1;
                    PC_WE     = 1'b1;
                    INST_DONE = 1'b1;
                    if (cls_q[CL_LD])                        WB_SEL = WBS_MEM;
                    else if (cls_q[CL_JAL] || cls_q[CL_JALR]) WB_SEL = WBS_PC4;
                    if (cls_q[CL_JAL])       PC_SEL = PCS_JAL;
                    else if (cls_q[CL_JALR]) PC_SEL = PCS_JALR;
                end
                default: ;
            endcase
        end
    end

endmodule
